v4_peak_sequencer: RTL and testbench

- Event sequencer placed after the v4 trapezoidal shaping filter.
- Watches the filter output, arms on a threshold crossing and waits out the flat-top window.
- Captures peak amplitude and trigger timestamp, enforces dead time after each event and flags pile-up.
- Captured events are buffered in a small FIFO and drained by the readout logic over a valid/ready handshake.

---
 rtl/v4_peak_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_v4_peak_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/v4_peak_sequencer.sv
// v4_peak_sequencer: threshold-armed peak/timestamp capture behind the v4 trapezoidal filter, with dead
// time, pile-up flagging and a show-ahead event FIFO. Optional baseline tracking: V4_SEQ_BASELINE_EN.

package package_settings;
    localparam int SIZE_FILTER_DATA = 16;
endpackage

module v4_peak_sequencer
    import package_settings::*;
#(
    parameter int FLAT_TOP   = 8,
    parameter int HOLDOFF    = 32,
    parameter int TS_W       = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               enable,
    input  logic signed [SIZE_FILTER_DATA-1:0] threshold,
    input  logic signed [SIZE_FILTER_DATA-1:0] filt_in,
    output logic                               evt_valid,
    input  logic                               evt_ready,
    output logic signed [SIZE_FILTER_DATA-1:0] evt_amp,
    output logic [TS_W-1:0]                    evt_ts,
    output logic                               evt_pileup,
    output logic                               busy,
    output logic [15:0]                        overflow_cnt
);
    localparam int DW      = SIZE_FILTER_DATA;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CNT_MAX = (FLAT_TOP > HOLDOFF) ? FLAT_TOP : HOLDOFF;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARMED   = 3'd1;
    localparam logic [2:0] S_RISE    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_HOLDOFF = 3'd4;

    localparam logic signed [DW+1:0] AMP_MAX = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [DW+1:0] AMP_MIN = {3'b111, {(DW-1){1'b0}}};

    logic [2:0]           state_q, state_d;
    logic [TS_W-1:0]      ts_q, ts_d, ts_trig_q, ts_trig_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic signed [DW-1:0] peak_q, peak_d;
    logic                 prev_above_q, prev_above_d;
    logic                 pend_pileup_q, pend_pileup_d;
    logic [15:0]          overflow_q, overflow_d;
    logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic signed [DW-1:0] head_amp_q, head_amp_d;
    logic [TS_W-1:0]      head_ts_q, head_ts_d;
    logic                 head_pileup_q, head_pileup_d;

    logic signed [DW-1:0] mem_amp    [FIFO_DEPTH];
    logic [TS_W-1:0]      mem_ts     [FIFO_DEPTH];
    logic                 mem_pileup [FIFO_DEPTH];

    logic signed [DW:0]   base;
    logic signed [DW+1:0] sig, thr_ext, amp_diff;
    logic signed [DW-1:0] push_amp;
    logic                 above, rise_edge, push, pop, full, empty, push_ok;
    logic [AW-1:0]        wr_idx, rd_idx_d;

`ifdef V4_SEQ_BASELINE_EN
    logic signed [DW:0] base_q, base_d;

    assign base = base_q;

    // The baseline only follows the quiet signal; it is frozen from trigger to the end of dead time.
    always_comb begin
        base_d = base_q;
        if (state_q == S_ARMED && !rise_edge)
            base_d = base_q + (DW+1)'(sig >>> 4);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) base_q <= '0;
        else          base_q <= base_d;
    end
`else
    assign base = '0;
`endif

    assign sig       = {{2{filt_in[DW-1]}}, filt_in} - {base[DW], base};
    assign thr_ext   = {{2{threshold[DW-1]}}, threshold};
    assign above     = sig > thr_ext;
    assign rise_edge = above && !prev_above_q;

    // Baseline is constant while a pulse is tracked, so the raw peak minus baseline is the shaped peak.
    assign amp_diff = {{2{peak_q[DW-1]}}, peak_q} - {base[DW], base};
    assign push_amp = (amp_diff > AMP_MAX) ? AMP_MAX[DW-1:0] :
                      (amp_diff < AMP_MIN) ? AMP_MIN[DW-1:0] : amp_diff[DW-1:0];

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        peak_d        = peak_q;
        ts_trig_d     = ts_trig_q;
        pend_pileup_d = pend_pileup_q;
        push          = 1'b0;
        ts_d          = ts_q + 1'b1;
        prev_above_d  = above;

        if (state_q != S_IDLE && !enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (enable) state_d = S_ARMED;
                S_ARMED: if (rise_edge) begin
                    state_d   = S_RISE;
                    cnt_d     = '0;
                    peak_d    = filt_in;
                    ts_trig_d = ts_q;
                end
                S_RISE: if (!above) begin
                    state_d = S_ARMED;
                end else begin
                    if (filt_in > peak_q) peak_d = filt_in;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(FLAT_TOP - 1)) state_d = S_CAPTURE;
                end
                S_CAPTURE: begin
                    push          = 1'b1;
                    pend_pileup_d = 1'b0;
                    state_d       = S_HOLDOFF;
                    cnt_d         = '0;
                end
                S_HOLDOFF: begin
                    if (rise_edge) pend_pileup_d = 1'b1;
                    if (cnt_q == CW'(HOLDOFF - 1)) state_d = S_ARMED;
                    else                           cnt_d   = cnt_q + 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop      = !empty && evt_ready;
    assign push_ok  = push && (!full || pop);
    assign wr_idx   = wr_ptr_q[AW-1:0];
    assign rd_idx_d = rd_ptr_d[AW-1:0];

    // Head registers keep the last entry visible after the FIFO drains.
    always_comb begin
        overflow_d    = overflow_q;
        wr_ptr_d      = wr_ptr_q + (AW+1)'(push_ok);
        rd_ptr_d      = rd_ptr_q + (AW+1)'(pop);
        head_amp_d    = head_amp_q;
        head_ts_d     = head_ts_q;
        head_pileup_d = head_pileup_q;
        if (push && !push_ok && overflow_q != 16'hFFFF)
            overflow_d = overflow_q + 1'b1;
        if (wr_ptr_d != rd_ptr_d) begin
            if (push_ok && wr_idx == rd_idx_d) begin
                head_amp_d    = push_amp;
                head_ts_d     = ts_trig_q;
                head_pileup_d = pend_pileup_q;
            end else begin
                head_amp_d    = mem_amp[rd_idx_d];
                head_ts_d     = mem_ts[rd_idx_d];
                head_pileup_d = mem_pileup[rd_idx_d];
            end
        end
    end

    // NOTE: storage is not reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_amp[wr_idx]    <= push_amp;
            mem_ts[wr_idx]     <= ts_trig_q;
            mem_pileup[wr_idx] <= pend_pileup_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            ts_q          <= '0;
            ts_trig_q     <= '0;
            cnt_q         <= '0;
            peak_q        <= '0;
            prev_above_q  <= 1'b0;
            pend_pileup_q <= 1'b0;
            overflow_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            head_amp_q    <= '0;
            head_ts_q     <= '0;
            head_pileup_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ts_q          <= ts_d;
            ts_trig_q     <= ts_trig_d;
            cnt_q         <= cnt_d;
            peak_q        <= peak_d;
            prev_above_q  <= prev_above_d;
            pend_pileup_q <= pend_pileup_d;
            overflow_q    <= overflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            head_amp_q    <= head_amp_d;
            head_ts_q     <= head_ts_d;
            head_pileup_q <= head_pileup_d;
        end
    end

    assign evt_valid    = !empty;
    assign evt_amp      = head_amp_q;
    assign evt_ts       = head_ts_q;
    assign evt_pileup   = head_pileup_q;
    assign busy         = (state_q == S_RISE) || (state_q == S_CAPTURE) || (state_q == S_HOLDOFF);
    assign overflow_cnt = overflow_q;

endmodule

// File: tb/tb_v4_peak_sequencer.sv
// Directed bench for v4_peak_sequencer: single-pulse vector table plus pile-up, FIFO full/overflow,
// mid-pulse reset and disable sequences. Edge 0 is the first rising edge after reset_n is released.

module tb_v4_peak_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset_n, enable, evt_ready, evt_valid, evt_pileup, busy;
    logic signed [15:0] threshold, filt_in, evt_amp;
    logic [31:0]        evt_ts;
    logic [15:0]        overflow_cnt;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int p0;

    v4_peak_sequencer #(.FLAT_TOP(8), .HOLDOFF(32), .TS_W(32), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .threshold(threshold), .filt_in(filt_in),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_amp(evt_amp), .evt_ts(evt_ts),
        .evt_pileup(evt_pileup), .busy(busy), .overflow_cnt(overflow_cnt)
    );

    always @(posedge clk)
        if (reset_n && evt_valid && evt_ready) pops <= pops + 1;

    typedef struct {
        int bg; int thr; int lvl; int len; int bump_edge; int bump_val;
        bit exp_evt; int exp_ts; int exp_amp; int busy_edge; bit exp_busy;
    } vec_t;
    vec_t vecs [12];

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step(input int v);
        filt_in = 16'(v);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int bg);
        reset_n = 1'b0;
        step(bg);
        step(bg);
        reset_n = 1'b1;
    endtask

    task automatic check_event(input string tag, input int ts, input int amp, input bit pu);
        check({tag, " valid"}, evt_valid, 1);
        check({tag, " ts"}, evt_ts, ts);
        check({tag, " amp"}, evt_amp, amp);
        check({tag, " pileup"}, evt_pileup, pu);
    endtask

    function automatic int pulse_level(input int k, input int n);
        for (int j = 0; j < n; j++)
            if (k >= 10 + 60*j && k <= 30 + 60*j) return 200 + 50*j;
        return 0;
    endfunction

    task automatic drain(input string tag, input int first, input int n);
        for (int j = first; j < first + n; j++) begin
            check_event($sformatf("%s q%0d", tag, j), 10 + 60*j, 200 + 50*j, 1'b0);
            evt_ready = 1'b1;
            step(0);
            evt_ready = 1'b0;
        end
        check({tag, " empty"}, evt_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        //          bg   thr  lvl  len bump bval evt ts  amp  bedge busy
        vecs[0]  = '{0,   100, 500, 21, -1,  0,   1, 10, 500, 25,  1};
        vecs[1]  = '{0,   100, 150, 3,  -1,  0,   0, 10, 0,   12,  1};
        vecs[2]  = '{0,   100, 101, 21, -1,  0,   1, 10, 101, 55,  0};
        vecs[3]  = '{0,   100, 100, 21, -1,  0,   0, 10, 0,   12,  0};
        vecs[4]  = '{0,   100, 500, 21, 15,  700, 1, 10, 700, 50,  1};
        vecs[5]  = '{0,   100, 500, 21, 18,  900, 1, 10, 900, 51,  0};
        vecs[6]  = '{0,   100, 500, 21, 19,  900, 1, 10, 500, 19,  1};
        vecs[7]  = '{0,   100, 300, 9,  -1,  0,   1, 10, 300, 18,  1};
        vecs[8]  = '{0,   100, 300, 8,  -1,  0,   0, 10, 0,   18,  0};
        vecs[9]  = '{-100, -50, -20, 21, -1,  0,   1, 10, -20, 30,  1};
        vecs[10] = '{500, 100, 500, 21, -1,  0,   0, 10, 0,   20,  0};
        vecs[11] = '{0,   100, 500, 21, 12,  50,  1, 13, 500, 12,  0};

        reset_n = 1'b0; enable = 1'b1; evt_ready = 1'b1; threshold = 16'sd100; filt_in = '0;
        do_reset(0);
        check("reset valid", evt_valid, 0);
        check("reset busy", busy, 0);
        check("reset amp", evt_amp, 0);
        check("reset ts", evt_ts, 0);
        check("reset pileup", evt_pileup, 0);
        check("reset overflow", overflow_cnt, 0);

        for (int i = 0; i < 12; i++) begin
            vec_t t;
            int   v;
            t = vecs[i];
            threshold = 16'(t.thr);
            do_reset(t.bg);
            p0 = pops;
            for (int k = 0; k < 70; k++) begin
                v = t.bg;
                if (k >= 10 && k < 10 + t.len) v = t.lvl;
                if (k == t.bump_edge) v = t.bump_val;
                step(v);
                if (k == t.busy_edge) check($sformatf("v%0d busy@%0d", i, k), busy, t.exp_busy);
                if (t.exp_evt && k == t.exp_ts + 8) check($sformatf("v%0d early valid", i), evt_valid, 0);
                if (t.exp_evt && k == t.exp_ts + 9) check_event($sformatf("v%0d", i), t.exp_ts, t.exp_amp, 1'b0);
            end
            check($sformatf("v%0d event count", i), pops - p0, t.exp_evt);
        end

        // Pile-up: B lands inside A's dead time and flags C; D afterwards is clean.
        threshold = 16'sd100;
        do_reset(0);
        p0 = pops;
        for (int k = 0; k < 140; k++) begin
            int v;
            v = 0;
            if (k >= 10 && k <= 30) v = 500;
            if (k >= 35 && k <= 40) v = 300;
            if (k >= 60 && k <= 90) v = 400;
            if (k >= 110 && k <= 130) v = 250;
            step(v);
            if (k == 19)  check_event("pile A", 10, 500, 1'b0);
            if (k == 45)  check("pile B none", evt_valid, 0);
            if (k == 69)  check_event("pile C", 60, 400, 1'b1);
            if (k == 119) check_event("pile D", 110, 250, 1'b0);
        end
        check("pile event count", pops - p0, 3);

        // Full FIFO: the fifth capture coincides with a pop, so nothing is dropped.
        do_reset(0);
        evt_ready = 1'b0;
        for (int k = 0; k < 320; k++) begin
            evt_ready = (k == 259);
            step(pulse_level(k, 5));
        end
        evt_ready = 1'b0;
        check("pushpop overflow", overflow_cnt, 0);
        drain("pushpop", 1, 4);

        // Overflow: six captures, four kept, two dropped, drained in order.
        do_reset(0);
        evt_ready = 1'b0;
        for (int k = 0; k < 380; k++) step(pulse_level(k, 6));
        check("ovf count", overflow_cnt, 2);
        drain("ovf", 0, 4);
        check("ovf hold ts", evt_ts, 190);
        check("ovf hold amp", evt_amp, 350);
        check("ovf count after drain", overflow_cnt, 2);

        // Reset in the middle of RISE.
        evt_ready = 1'b1;
        for (int k = 0; k < 14; k++) step(k >= 10 ? 500 : 0);
        check("mid busy before reset", busy, 1);
        reset_n = 1'b0;
        step(500);
        check("mid reset valid", evt_valid, 0);
        check("mid reset busy", busy, 0);
        check("mid reset amp", evt_amp, 0);
        check("mid reset ts", evt_ts, 0);
        check("mid reset pileup", evt_pileup, 0);
        check("mid reset overflow", overflow_cnt, 0);
        reset_n = 1'b1;
        p0 = pops;
        for (int k = 0; k < 41; k++) begin
            step((k >= 10 && k <= 30) ? 450 : 0);
            if (k == 19) check_event("after reset", 10, 450, 1'b0);
        end
        check("after reset event count", pops - p0, 1);

        // Disable with two events queued; later pulses are ignored, queue still drains.
        do_reset(0);
        evt_ready = 1'b0;
        for (int k = 0; k < 260; k++) begin
            int v;
            v = 0;
            if (k >= 10 && k <= 30) v = 500;
            if (k >= 70 && k <= 90) v = 300;
            if ((k >= 130 && k <= 150) || (k >= 190 && k <= 210)) v = 400;
            enable = (k < 100);
            step(v);
            if (k == 132) check("dis busy", busy, 0);
        end
        check("dis overflow", overflow_cnt, 0);
        check_event("dis q0", 10, 500, 1'b0);
        evt_ready = 1'b1;
        step(0);
        check_event("dis q1", 70, 300, 1'b0);
        step(0);
        check("dis empty", evt_valid, 0);
        check("dis overflow after drain", overflow_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
